// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Logic and arithmetic ops finish in one cycle; shifts step one bit per cycle.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            alu_control_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;

    logic                  accept;
    logic                  is_shift;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] acc_step;

    assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept   = valid_i && ready_o;
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);

    assign shamt    = src_b_i[4:0];
    assign is_shift = (alu_control_i == OP_SLL) || (alu_control_i == OP_SRL) ||
                      (alu_control_i == OP_SRA);

    // Single-cycle result; shift codes only reach here with amount 0, so they pass a through.
    always_comb begin
        alu_res = '0;
        case (alu_control_i)
            OP_ADD:  alu_res = src_a_i + src_b_i;
            OP_SUB:  alu_res = src_a_i - src_b_i;
            OP_AND:  alu_res = src_a_i & src_b_i;
            OP_OR:   alu_res = src_a_i | src_b_i;
            OP_XOR:  alu_res = src_a_i ^ src_b_i;
            OP_SLL, OP_SRL, OP_SRA: alu_res = src_a_i;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (src_a_i < src_b_i)};
            OP_LUI:  alu_res = {src_b_i[DATA_WIDTH-13:0], 12'b0};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OP_SLL:  acc_step = {acc_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc_q[DATA_WIDTH-1:1]};
            OP_SRA:  acc_step = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        acc_d   = src_a_i;
                        cnt_d   = shamt;
                        op_d    = alu_control_i;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        state_d  = DONE;
                    end
                end else if (state_q == DONE && ready_i) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = acc_step;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  alu_control_i = '0;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        zero_o;

    int vectors = 0;
    int miscompares = 0;

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .alu_control_i(alu_control_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] code, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        int sh;
        sa = a; sb = b; sh = int'(b % 32);
        case (code)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd9:    return sa >>> sh;
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd15:   return b * 32'd4096;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] code, input logic [31:0] b);
        if ((code == 4'd5 || code == 4'd6 || code == 4'd9) && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
    endfunction

    // Presents one op, then waits (bounded) for its result with ready_i as set by the caller.
    task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat,
                         output int lowcnt, output bit tmo);
        int w;
        tmo = 0; w = 0;
        valid_i = 1'b1; alu_control_i = code; src_a_i = a; src_b_i = b;
        while (!ready_o && w < 60) begin step(); w++; end
        step();
        valid_i = 1'b0; alu_control_i = $urandom; src_a_i = $urandom; src_b_i = $urandom;
        lat = 1; lowcnt = 0;
        while (!valid_o && lat < 60) begin
            if (!ready_o) lowcnt++;
            step(); lat++;
        end
        if (w >= 60 || lat >= 60) tmo = 1;
        res = result_o; z = zero_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        vectors++;
        if (valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b result=%h zero=%b, want 0/00000000/1",
                     valid_o, result_o, zero_o);
        end
        step(); step();
        rst_ni = 1'b1;
        #1;
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: ready_o=%b want 1", ready_o);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        valid_i = 1'b1; alu_control_i = 4'd0; src_a_i = 32'd5; src_b_i = 32'd7;
        step();
        alu_control_i = 4'd1; src_a_i = 32'd3; src_b_i = 32'd3;
        vectors++;
        if (valid_o !== 1'b1 || result_o !== 32'd12 || zero_o !== 1'b0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_add: valid=%b result=%h zero=%b ready=%b, want 1/0000000c/0/1",
                     valid_o, result_o, zero_o, ready_o);
        end
        step();
        valid_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b1 || result_o !== 32'd0 || zero_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_sub: valid=%b result=%h zero=%b, want 1/00000000/1",
                     valid_o, result_o, zero_o);
        end
        step();
    endtask

    // Directed corner operands: SLT/SLTU sign split, immediate-upper, shifts, undefined codes.
    task automatic test_directed();
        logic [3:0]  codes[8] = '{4'd7, 4'd8, 4'd15, 4'd9, 4'd6, 4'd5, 4'd11, 4'd10};
        logic [31:0] as[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
                               32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] bs[8] = '{32'd1, 32'd1, 32'h0001_2345, 32'h24, 32'h24, 32'hFFFF_FFE0,
                               32'hFFFF_FFFF, 32'h1};
        logic [31:0] want[8] = '{32'd1, 32'd0, 32'h1234_5000, 32'hF800_0000, 32'h0800_0000,
                                 32'hDEAD_BEEF, 32'd0, 32'd0};
        int wlat[8] = '{1, 1, 1, 5, 5, 1, 1, 1};
        logic [31:0] r; logic z; int lat, lowc; bit tmo;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_op(codes[i], as[i], bs[i], r, z, lat, lowc, tmo);
            vectors++;
            if (tmo || r !== want[i] || z !== (want[i] == 0) || lat != wlat[i] ||
                lowc != wlat[i] - 1) begin
                miscompares++;
                $display("FAIL directed[%0d] code=%h: result=%h zero=%b lat=%0d rdylow=%0d tmo=%0d, want %h/%b/%0d/%0d",
                         i, codes[i], r, z, lat, lowc, tmo, want[i], want[i] == 0, wlat[i], wlat[i] - 1);
            end
        end
        step();
    endtask

    task automatic test_stall();
        logic [31:0] r; logic z; int lat, lowc; bit tmo;
        ready_i = 1'b0;
        do_op(4'd0, 32'd100, 32'd23, r, z, lat, lowc, tmo);
        valid_i = 1'b1; alu_control_i = 4'd1; src_a_i = 32'd10; src_b_i = 32'd4;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (valid_o !== 1'b1 || result_o !== 32'd123 || ready_o !== 1'b0 || tmo) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b result=%h ready=%b, want 1/0000007b/0",
                         i, valid_o, result_o, ready_o);
            end
            step();
        end
        ready_i = 1'b1;
        #1;
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_ready: ready_o=%b want 1", ready_o);
        end
        step();
        valid_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b1 || result_o !== 32'd6) begin
            miscompares++;
            $display("FAIL stall_newop: valid=%b result=%h, want 1/00000006", valid_o, result_o);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r; logic z; int lat, lowc; bit tmo;
        ready_i = 1'b1;
        valid_i = 1'b1; alu_control_i = 4'd5; src_a_i = 32'h0000_0001; src_b_i = 32'd10;
        step();
        valid_i = 1'b0;
        step(); step();
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midshift_reset: valid=%b result=%h zero=%b, want 0/00000000/1",
                     valid_o, result_o, zero_o);
        end
        step();
        rst_ni = 1'b1;
        #1;
        vectors++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midshift_after: ready=%b valid=%b, want 1/0", ready_o, valid_o);
        end
        do_op(4'd0, 32'hFFFF_FFFF, 32'd2, r, z, lat, lowc, tmo);
        vectors++;
        if (tmo || r !== 32'd1 || z !== 1'b0 || lat != 1) begin
            miscompares++;
            $display("FAIL midshift_add: result=%h zero=%b lat=%0d, want 00000001/0/1", r, z, lat);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] a, b, want, r; logic [3:0] code; logic z; int lat, lowc, wl; bit tmo;
        for (int i = 0; i < 300; i++) begin
            code = 4'($urandom);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
            if ($urandom_range(0, 7) == 0) b = a;
            want = ref_result(code, a, b);
            wl = ref_latency(code, b);
            ready_i = 1'b1;
            do_op(code, a, b, r, z, lat, lowc, tmo);
            vectors++;
            if (tmo || r !== want || z !== (want == 0) || lat != wl || lowc != wl - 1) begin
                miscompares++;
                $display("FAIL random[%0d] code=%h a=%h b=%h: result=%h zero=%b lat=%0d rdylow=%0d, want %h/%b/%0d/%0d",
                         i, code, a, b, r, z, lat, lowc, want, want == 0, wl, wl - 1);
            end
            if ($urandom_range(0, 1) == 0) begin
                ready_i = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                vectors++;
                if (valid_o !== 1'b1 || result_o !== want) begin
                    miscompares++;
                    $display("FAIL random_hold[%0d]: valid=%b result=%h, want 1/%h",
                             i, valid_o, result_o, want);
                end
                ready_i = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_stall();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
